prog_timer: RTL

Parametrised successor to the fixed-count one-shot timer. Adds a runtime load value, one-shot or periodic mode, a clock prescaler, pause (hold), stop and a readable remaining count. Used as a general-purpose interval and timeout generator next to protocol FSMs, where a one-cycle done pulse is needed N*(P+1) cycles after start.

---
 rtl/timer_pkg.sv | 14 +
 rtl/timer_prescaler.sv | 47 ++++
 rtl/prog_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and limits for the programmable interval timer.
// FSM state encoding and the legal WIDTH range.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: emits a tick every prescale+1 enabled clocks.
// The divisor is latched on load so mid-run changes wait for a reload.
module timer_prescaler #(
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);
  import timer_pkg::*;

  localparam logic [PRESCALE_WIDTH-1:0] ONE =
    PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;

  assign tick = enable && (cnt_q == '0);

  // Load wins; otherwise count down and wrap to the latched divisor.
  always_comb begin
    cnt_d = cnt_q;
    pre_d = pre_q;
    if (load) begin
      cnt_d = prescale;
      pre_d = prescale;
    end else if (enable) begin
      if (cnt_q == '0) cnt_d = pre_q;
      else             cnt_d = cnt_q - ONE;
    end
  end

  // Prescaler count and latched divisor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable one-shot / periodic interval timer with prescaler,
// hold, stop and a readable remaining-tick count.
module prog_timer #(
  parameter int WIDTH          = 16,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      hold,
  input  logic                      periodic,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      done,
  output logic                      busy,
  output logic                      err,
  output logic [WIDTH-1:0]          remaining
);
  import timer_pkg::*;

  localparam logic [WIDTH-1:0] REM_ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             start_prev_q, start_prev_d;

  logic pre_load;
  logic pre_en;
  logic tick;
  logic term;
  logic zero_load;
  logic start_eff;

  assign busy      = (state_q != IDLE);
  assign pre_en    = busy && !hold;
  assign term      = tick && (rem_q == REM_ONE);
  assign zero_load = (load_value == '0);
  // A start held high only restarts a running timer at its
  // terminal tick, so a held start yields back-to-back intervals.
  assign start_eff = start &&
    (!busy || !start_prev_q || term);

  timer_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .load    (pre_load),
    .enable  (pre_en),
    .prescale(prescale),
    .tick    (tick)
  );

  // Next state: stop > start > hold > counting.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    mode_d       = mode_q;
    done_d       = 1'b0;
    err_d        = 1'b0;
    pre_load     = 1'b0;
    start_prev_d = start;
    if (stop) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (start && zero_load) begin
      err_d   = 1'b1;
      state_d = IDLE;
      rem_d   = '0;
    end else if (start_eff) begin
      done_d   = term;
      state_d  = RUN;
      rem_d    = load_value;
      mode_d   = periodic;
      pre_load = 1'b1;
    end else if (busy) begin
      if (hold) begin
        state_d = HOLD;
      end else begin
        state_d = RUN;
        if (tick) begin
          if (rem_q > REM_ONE) begin
            rem_d = rem_q - REM_ONE;
          end else begin
            done_d = 1'b1;
            if (!mode_q) begin
              state_d = IDLE;
              rem_d   = '0;
            end else if (zero_load) begin
              err_d   = 1'b1;
              state_d = IDLE;
              rem_d   = '0;
            end else begin
              rem_d    = load_value;
              pre_load = 1'b1;
            end
          end
        end
      end
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      mode_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      mode_q       <= mode_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign remaining = rem_q;

endmodule
